// File: rtl/sbqm_queue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sbqm_queue_ctrl: customer counter with round-robin teller calling.         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sbqm_queue_ctrl #(
  parameter int N_TELLERS = 3,
  parameter int TW        = 2,
  parameter int MAX_COUNT = 7,
  parameter int CW        = 3,
  parameter int SVC_MIN   = 3,
  parameter int EW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_pulse,
  input  logic [N_TELLERS-1:0] teller_done,
  output logic [CW-1:0]        pcount,
  output logic                 empty,
  output logic                 full,
  output logic                 call_valid,
  output logic [TW-1:0]        call_teller,
  output logic                 rejected,
  output logic [EW-1:0]        wait_est
);

  localparam logic [31:0] WAIT_MAX = (32'd1 << EW) - 32'd1;

  logic [N_TELLERS-1:0] pending_q, pending_d;
  logic [TW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        pcount_q, pcount_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 call_valid_q, call_valid_d;
  logic [TW-1:0]        call_teller_q, call_teller_d;
  logic                 rejected_q, rejected_d;
  logic [EW-1:0]        wait_est_q, wait_est_d;

  logic                 found;
  logic [TW-1:0]        winner;
  logic                 grant_req;
  logic                 inc;
  logic [N_TELLERS-1:0] grant_onehot;
  logic [31:0]          prod;

  // First pending teller at or above rr_ptr, wrapping at N_TELLERS.
  always_comb begin
    logic [31:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_TELLERS; i++) begin
      idx = 32'(rr_ptr_q) + 32'(i);
      if (idx >= 32'(N_TELLERS)) idx = idx - 32'(N_TELLERS);
      if (!found && pending_q[idx[TW-1:0]]) begin
        found  = 1'b1;
        winner = idx[TW-1:0];
      end
    end
  end

  always_comb begin
    grant_req = (pcount_q != '0) && found;
    for (int j = 0; j < N_TELLERS; j++) begin
      grant_onehot[j] = grant_req && (winner == TW'(j));
    end

    pending_d = (pending_q & ~grant_onehot) | teller_done;

    rr_ptr_d      = rr_ptr_q;
    call_teller_d = call_teller_q;
    call_valid_d  = grant_req;
    if (grant_req) begin
      call_teller_d = winner;
      rr_ptr_d      = (winner == TW'(N_TELLERS - 1)) ? '0 : winner + TW'(1);
    end

    // A grant frees a slot, so a full queue still admits a simultaneous entry.
    inc        = entry_pulse && ((pcount_q < CW'(MAX_COUNT)) || grant_req);
    rejected_d = entry_pulse && !inc;

    pcount_d = pcount_q;
    if (inc && !grant_req)      pcount_d = pcount_q + CW'(1);
    else if (!inc && grant_req) pcount_d = pcount_q - CW'(1);

    empty_d = (pcount_d == '0);
    full_d  = (pcount_d == CW'(MAX_COUNT));

    prod       = 32'(pcount_d) * 32'(SVC_MIN);
    wait_est_d = (prod > WAIT_MAX) ? {EW{1'b1}} : prod[EW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      pcount_q      <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      call_valid_q  <= 1'b0;
      call_teller_q <= '0;
      rejected_q    <= 1'b0;
      wait_est_q    <= '0;
    end else begin
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      pcount_q      <= pcount_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      call_valid_q  <= call_valid_d;
      call_teller_q <= call_teller_d;
      rejected_q    <= rejected_d;
      wait_est_q    <= wait_est_d;
    end
  end

  assign pcount      = pcount_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign call_valid  = call_valid_q;
  assign call_teller = call_teller_q;
  assign rejected    = rejected_q;
  assign wait_est    = wait_est_q;

endmodule
`default_nettype wire

// File: tb/tb_sbqm_queue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sbqm_queue_ctrl: directed bench for the queue controller.               |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sbqm_queue_ctrl;

  logic       clk;
  logic       reset;
  logic       entry_pulse;
  logic [2:0] teller_done;
  logic [2:0] pcount;
  logic       empty;
  logic       full;
  logic       call_valid;
  logic [1:0] call_teller;
  logic       rejected;
  logic [7:0] wait_est;

  int tests;
  int fails;

  sbqm_queue_ctrl #(
    .N_TELLERS(3), .TW(2), .MAX_COUNT(7), .CW(3), .SVC_MIN(3), .EW(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entry_pulse(entry_pulse),
    .teller_done(teller_done),
    .pcount     (pcount),
    .empty      (empty),
    .full       (full),
    .call_valid (call_valid),
    .call_teller(call_teller),
    .rejected   (rejected),
    .wait_est   (wait_est)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, sample 1 ns after the rising edge.
  task automatic tick(input logic e, input logic [2:0] td);
    entry_pulse = e;
    teller_done = td;
    @(posedge clk);
    #1;
    entry_pulse = 1'b0;
    teller_done = 3'b000;
  endtask

  task automatic chk_call(input string tag, input logic v, input logic [1:0] t, input logic [2:0] n);
    chk({tag, "_valid"},  32'(call_valid),  32'(v));
    chk({tag, "_teller"}, 32'(call_teller), 32'(t));
    chk({tag, "_pcount"}, 32'(pcount),      32'(n));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b0;
    entry_pulse = 1'b0;
    teller_done = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcount", 32'(pcount), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_call_valid", 32'(call_valid), 0);
    chk("rst_call_teller", 32'(call_teller), 0);
    chk("rst_rejected", 32'(rejected), 0);
    chk("rst_wait", 32'(wait_est), 0);
    reset = 1'b1;

    // Reset and fill
    tick(1'b1, 3'b000);
    chk("fill1_pcount", 32'(pcount), 1);
    chk("fill1_wait", 32'(wait_est), 3);
    chk("fill1_empty", 32'(empty), 0);
    tick(1'b1, 3'b000);
    tick(1'b1, 3'b000);
    chk("fill3_pcount", 32'(pcount), 3);
    chk("fill3_empty", 32'(empty), 0);
    chk("fill3_wait", 32'(wait_est), 9);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pcount", 32'(pcount), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_wait", 32'(wait_est), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Overflow
    for (int i = 0; i < 7; i++) tick(1'b1, 3'b000);
    chk("ovf7_pcount", 32'(pcount), 7);
    chk("ovf7_full", 32'(full), 1);
    chk("ovf7_rejected", 32'(rejected), 0);
    chk("ovf7_wait", 32'(wait_est), 21);
    tick(1'b1, 3'b000);
    chk("ovf8_pcount", 32'(pcount), 7);
    chk("ovf8_rejected", 32'(rejected), 1);
    chk("ovf8_full", 32'(full), 1);
    tick(1'b0, 3'b000);
    chk("ovf9_rejected", 32'(rejected), 0);

    // Round-robin
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 3'b000);
    chk("rr_pcount5", 32'(pcount), 5);
    tick(1'b0, 3'b111);
    chk_call("rr_arm", 1'b0, 2'd0, 3'd5);
    tick(1'b0, 3'b000);
    chk_call("rr_g0", 1'b1, 2'd0, 3'd4);
    tick(1'b0, 3'b000);
    chk_call("rr_g1", 1'b1, 2'd1, 3'd3);
    tick(1'b0, 3'b000);
    chk_call("rr_g2", 1'b1, 2'd2, 3'd2);
    tick(1'b0, 3'b000);
    chk_call("rr_idle", 1'b0, 2'd2, 3'd2);
    tick(1'b0, 3'b101);
    chk_call("rr_arm2", 1'b0, 2'd2, 3'd2);
    tick(1'b0, 3'b000);
    chk_call("rr_wrap0", 1'b1, 2'd0, 3'd1);
    tick(1'b0, 3'b000);
    chk_call("rr_then2", 1'b1, 2'd2, 3'd0);
    tick(1'b0, 3'b000);
    chk_call("rr_done", 1'b0, 2'd2, 3'd0);
    chk("rr_empty", 32'(empty), 1);

    // Empty hold
    tick(1'b0, 3'b010);
    chk("eh_arm_valid", 32'(call_valid), 0);
    tick(1'b0, 3'b000);
    chk("eh_hold_valid", 32'(call_valid), 0);
    tick(1'b1, 3'b000);
    chk_call("eh_entry", 1'b0, 2'd2, 3'd1);
    tick(1'b0, 3'b000);
    chk_call("eh_grant", 1'b1, 2'd1, 3'd0);
    chk("eh_empty", 32'(empty), 1);

    // Simultaneous entry and grant while full
    for (int i = 0; i < 7; i++) tick(1'b1, 3'b000);
    chk("sf_full", 32'(full), 1);
    tick(1'b0, 3'b001);
    chk_call("sf_arm", 1'b0, 2'd1, 3'd7);
    tick(1'b1, 3'b000);
    chk_call("sf_grant", 1'b1, 2'd0, 3'd7);
    chk("sf_rejected", 32'(rejected), 0);
    chk("sf_full2", 32'(full), 1);

    // Re-arm in the grant cycle
    tick(1'b0, 3'b001);
    chk_call("ra_arm", 1'b0, 2'd0, 3'd7);
    tick(1'b0, 3'b001);
    chk_call("ra_g1", 1'b1, 2'd0, 3'd6);
    tick(1'b0, 3'b000);
    chk_call("ra_g2", 1'b1, 2'd0, 3'd5);
    tick(1'b0, 3'b000);
    chk_call("ra_idle", 1'b0, 2'd0, 3'd5);
    chk("ra_wait", 32'(wait_est), 15);
    chk("ra_full", 32'(full), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sbqm_queue_ctrl.md
# sbqm_queue_ctrl

Queue controller for the bank queue-management system. It counts customers admitted by the entry photocell and assigns the next waiting customer to a free teller using round-robin arbitration. It also publishes the occupancy, full/empty status and an estimated waiting time. Its inputs are the one-cycle pulses from the entry photocell FSM and the teller "ready" buttons. Its outputs drive the display and caller logic.

## Interface

**Parameters**
- `N_TELLERS`, 3: number of teller request inputs (2..8).
- `TW`, 2: width of the teller index; must satisfy 2^TW >= N_TELLERS.
- `MAX_COUNT`, 7: queue capacity.
- `CW`, 3: width of the count; must satisfy 2^CW > MAX_COUNT.
- `SVC_MIN`, 3: average service time per customer, in minutes.
- `EW`, 8: width of the wait estimate.

**Ports**
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `entry_pulse`, input, 1: one-cycle pulse from the entry photocell FSM; one customer joined.
- `teller_done`, input, N_TELLERS: one-cycle pulse per teller; that teller is free for the next customer.
- `pcount`, output, CW: number of customers waiting.
- `empty`, output, 1: high when `pcount == 0`.
- `full`, output, 1: high when `pcount == MAX_COUNT`.
- `call_valid`, output, 1: one-cycle pulse; a customer is called to teller `call_teller`.
- `call_teller`, output, TW: index of the called teller; holds its last value when `call_valid` is low.
- `rejected`, output, 1: one-cycle pulse; an entry was dropped because the queue was full.
- `wait_est`, output, EW: estimated wait in minutes.

## Operation

**Internal state**
- `pending[N_TELLERS-1:0]`: registered "teller free" flags.
- `rr_ptr` (TW bits): round-robin start index.
- `pcount`: the customer count.

**Pending flags**
- Update rule: `pending_next = (pending & ~grant_onehot) | teller_done`.
- A pulse arriving in the same cycle that its teller is granted re-arms the flag.
- A pulse arriving while the flag is already set has no further effect.

**Grant**
- Evaluated every cycle from registered state only.
- `grant_req = (pcount != 0) && (pending != 0)`.
- The winner is the first set `pending` bit searching upward from `rr_ptr`, wrapping past `N_TELLERS-1` to 0.
- On a grant:
  - `call_valid` <= 1 and `call_teller` <= winner.
  - `rr_ptr` <= winner+1, wrapping to 0 after `N_TELLERS-1`.
  - The winner's pending bit is cleared.
- At most one grant per cycle.

**Count update**
- `inc = entry_pulse && (pcount < MAX_COUNT || grant_req)`.
- `dec = grant_req`.
- `pcount_next = pcount + inc - dec`.
- Entry and grant in the same cycle leave the count unchanged. This applies when full as well: the freed slot admits the entry.
- If `entry_pulse` is high, the queue is full and there is no grant: the entry is dropped, `rejected` <= 1 and `pcount` holds.
- `pcount` never exceeds `MAX_COUNT` and never underflows.

**Status outputs**
- `empty`, `full` and `wait_est` are registered and derived from `pcount_next`, so they stay consistent with `pcount` in every cycle.
- `wait_est = pcount * SVC_MIN`, saturated to 2^EW - 1.

**Reset values**
- `pcount`=0, `empty`=1, `full`=0.
- `call_valid`=0, `call_teller`=0, `rejected`=0, `wait_est`=0.
- `pending`=0, `rr_ptr`=0.
- Reset asserted mid-operation discards all queued customers and pending tellers. The first edge after release behaves as a fresh start.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- **Entry latency:** `entry_pulse` sampled at edge k → `pcount`, `empty`, `full` and `wait_est` update at edge k.
- **Teller latency:** `teller_done` sampled at edge k → `pending` set at edge k → earliest `call_valid` at edge k+1, with `pcount` decremented at that same edge.
- **Empty queue:** `entry_pulse` at edge k into an empty queue with a pending teller → the grant fires at edge k+1. A customer is never granted in the cycle they arrive.
- **Pulse outputs:** `call_valid` and `rejected` are each high for exactly one cycle per event.
- **Back-to-back grants:** one per cycle is possible while several tellers are pending and `pcount > 0`.

## Test plan

- **Reset and fill.** Release reset, then give 3 `entry_pulse`s.
  - Required: `pcount`=3, `empty`=0, `wait_est`=9 with SVC_MIN=3.
  - Then assert `reset`=0 mid-run: all outputs return to their reset values immediately.
- **Overflow.** Give 8 entry pulses with no tellers pending.
  - Required: `pcount` saturates at 7, `full`=1, one `rejected` pulse on the 8th entry.
- **Round-robin.** `pcount`=5; pulse `teller_done`=3'b111 in one cycle.
  - Required: `call_teller` = 0, 1, 2 on three consecutive cycles, `pcount` 5→2.
  - Then pulse tellers 0 and 2 together: teller 0 wins (`rr_ptr` wrapped to 0), teller 2 is called next cycle.
- **Empty hold.** `pcount`=0; pulse `teller_done[1]`.
  - Required: no `call_valid`.
  - Then an entry at edge k: `call_valid`=1, `call_teller`=1 at edge k+1, `pcount` 1→0.
- **Simultaneous full.** Queue full (`pcount`=7), teller 0 pending, `entry_pulse` in the grant cycle.
  - Required: `pcount` stays 7, `rejected`=0, `call_valid`=1.
- **Re-arm.** `teller_done[0]` pulses in the same cycle teller 0 is granted, with `pcount`≥2.
  - Required: teller 0 is granted again on the next cycle when it is the only pending teller.
